seven_seg_scan: RTL and testbench

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits. It captures a packed hex word into a shadow register and scans one digit per refresh slot. Each slot inserts a one-cycle anode-off guard against ghosting. It adds per-digit decimal points, enables, blink and leading-zero suppression. It sits between the datapath or debug registers and the board display pins.

---
 rtl/seven_seg_scan.sv | 153 +++++++++++++++
 tb/tb_seven_seg_scan.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with shadowed digits, guard cycle,
// per-digit decimal points, enables, blink and leading-zero blanking. All state moves on the falling edge.
module seven_seg_scan #(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_suppress,
  output logic [7:0]            segments,
  output logic [DIGITS-1:0]     anodes,
  output logic                  frame_done
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [DIGITS-1:0][3:0] nib_q, nib_d;
  logic [DIGITS-1:0]      dp_q, dp_d;
  logic [DIGITS-1:0]      en_q, en_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FRM_W-1:0]       frm_q, frm_d;
  logic                   phase_q, phase_d;
  logic [7:0]             seg_q, seg_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic                   fd_q, fd_d;

  logic slot_end_c;
  logic frame_end_c;
  logic upper_zero_c;
  logic blank_c;

  function automatic logic [7:0] font(input logic [3:0] n);
    logic [7:0] f;
    case (n)
      4'h0: f = 8'hC0;
      4'h1: f = 8'hF9;
      4'h2: f = 8'hA4;
      4'h3: f = 8'hB0;
      4'h4: f = 8'h99;
      4'h5: f = 8'h92;
      4'h6: f = 8'h82;
      4'h7: f = 8'hF8;
      4'h8: f = 8'h80;
      4'h9: f = 8'h90;
      4'hA: f = 8'h88;
      4'hB: f = 8'h83;
      4'hC: f = 8'hC6;
      4'hD: f = 8'hA1;
      4'hE: f = 8'h86;
      default: f = 8'h8E;
    endcase
    return f;
  endfunction

  // Next-state: shadow capture, slot/digit/frame counters, blink phase and output decode
  always_comb begin
    nib_d   = nib_q;
    dp_d    = dp_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frm_d   = frm_q;
    phase_d = phase_q;
    seg_d   = 8'hFF;
    an_d    = '1;

    if (load) begin
      nib_d = data;
      dp_d  = dp_in;
      en_d  = digit_en;
    end

    slot_end_c  = (cnt_q == CNT_LAST);
    frame_end_c = slot_end_c && (idx_q == IDX_LAST);

    if (slot_end_c) begin
      cnt_d = '0;
      idx_d = frame_end_c ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (frame_end_c) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end

    // Leading zero: the current digit and every more-significant nibble are zero
    upper_zero_c = 1'b1;
    for (int j = 0; j < int'(DIGITS); j++) begin
      if ((IDX_W'(j) >= idx_q) && (nib_q[j] != 4'h0)) upper_zero_c = 1'b0;
    end

    blank_c = !en_q[idx_q]
           || (blink_mask[idx_q] && !phase_q)
           || (lz_suppress && (idx_q != '0) && upper_zero_c);

    if ((cnt_q != '0) && !blank_c) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = font(nib_q[idx_q]) & {~dp_q[idx_q], 7'h7F};
    end

    fd_d = frame_end_c;
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nib_q   <= '0;
      dp_q    <= '0;
      en_q    <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      phase_q <= 1'b1;
      seg_q   <= 8'hFF;
      an_q    <= '1;
      fd_q    <= 1'b0;
    end else begin
      nib_q   <= nib_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
    end
  end

  assign segments   = seg_q;
  assign anodes     = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
// Edge k after reset release reflects slot position cnt=(k-1)%4, digit=((k-1)/4)%4.
module tb_seven_seg_scan;

  localparam int unsigned DIGITS = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  blink_mask;
  logic        lz_suppress;
  logic [7:0]  segments;
  logic [3:0]  anodes;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int k     = 0;

  logic [7:0] font_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seven_seg_scan #(.DIGITS(4), .REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset_n(reset_n), .data(data), .load(load), .dp_in(dp_in),
    .digit_en(digit_en), .blink_mask(blink_mask), .lz_suppress(lz_suppress),
    .segments(segments), .anodes(anodes), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
    k++;
  endtask

  task automatic hold_reset();
    reset_n = 1'b0; load = 1'b0; data = '0; dp_in = '0; digit_en = '0;
    blink_mask = '0; lz_suppress = 1'b0;
    #3;
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    k = 0;
  endtask

  task automatic load_word(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    data = d; dp_in = dp; digit_en = en; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    hold_reset();
    tick();
    tick();
    n_cmp++; if (segments !== 8'hFF) begin n_err++; $display("FAIL reset_seg got=%h exp=FF", segments); end
    n_cmp++; if (anodes !== 4'hF) begin n_err++; $display("FAIL reset_an got=%h exp=F", anodes); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
  endtask

  task automatic test_scan();
    logic [7:0] scan_seg [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_fd;
    int c, i;
    release_reset();
    load_word(16'h1234, 4'h0, 4'hF);
    n_cmp++; if (anodes !== 4'hF || segments !== 8'hFF) begin
      n_err++; $display("FAIL scan_first_guard got an=%h seg=%h exp an=F seg=FF", anodes, segments);
    end
    for (int e = 0; e < 31; e++) begin
      tick();
      c = (k - 1) % 4;
      i = ((k - 1) / 4) % 4;
      exp_an  = (c == 0) ? 4'hF : ~(4'b0001 << i);
      exp_seg = (c == 0) ? 8'hFF : scan_seg[i];
      exp_fd  = (k % 16 == 0);
      n_cmp++; if (anodes !== exp_an || segments !== exp_seg || frame_done !== exp_fd) begin
        n_err++; $display("FAIL scan k=%0d got an=%h seg=%h fd=%b exp an=%h seg=%h fd=%b",
                          k, anodes, segments, frame_done, exp_an, exp_seg, exp_fd);
      end
    end
  endtask

  task automatic test_font();
    for (int n = 0; n < 16; n++) begin
      hold_reset();
      release_reset();
      load_word(16'(n), 4'h0, 4'h1);
      tick();
      n_cmp++; if (anodes !== 4'hE || segments !== font_tbl[n]) begin
        n_err++; $display("FAIL font nib=%0h got an=%h seg=%h exp an=E seg=%h", n, anodes, segments, font_tbl[n]);
      end
    end
    hold_reset();
    release_reset();
    load_word(16'h0008, 4'h1, 4'h1);
    tick();
    n_cmp++; if (anodes !== 4'hE || segments !== 8'h00) begin
      n_err++; $display("FAIL font_dp got an=%h seg=%h exp an=E seg=00", anodes, segments);
    end
  endtask

  task automatic test_lz();
    logic [7:0] exp_seg;
    logic [3:0] exp_an;
    int c, i;
    for (int pass = 0; pass < 2; pass++) begin
      hold_reset();
      release_reset();
      lz_suppress = 1'b1;
      load_word((pass == 0) ? 16'h0040 : 16'h0000, 4'h0, 4'hF);
      for (int e = 0; e < 15; e++) begin
        tick();
        c = (k - 1) % 4;
        i = ((k - 1) / 4) % 4;
        exp_an = 4'hF; exp_seg = 8'hFF;
        if (c != 0 && (i == 0 || (pass == 0 && i == 1))) begin
          exp_an  = ~(4'b0001 << i);
          exp_seg = (i == 1) ? 8'h99 : 8'hC0;
        end
        n_cmp++; if (anodes !== exp_an || segments !== exp_seg) begin
          n_err++; $display("FAIL lz pass=%0d k=%0d got an=%h seg=%h exp an=%h seg=%h",
                            pass, k, anodes, segments, exp_an, exp_seg);
        end
      end
    end
  endtask

  task automatic test_blink();
    logic [7:0] scan_seg [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_fd;
    int c, i, f;
    hold_reset();
    release_reset();
    blink_mask = 4'b0001;
    load_word(16'h1234, 4'h0, 4'hF);
    for (int e = 0; e < 95; e++) begin
      tick();
      c = (k - 1) % 4;
      i = ((k - 1) / 4) % 4;
      f = (k - 1) / 16 + 1;
      exp_an = 4'hF; exp_seg = 8'hFF;
      if (c != 0 && !(i == 0 && (f == 3 || f == 4))) begin
        exp_an  = ~(4'b0001 << i);
        exp_seg = scan_seg[i];
      end
      exp_fd = (k % 16 == 0);
      n_cmp++; if (anodes !== exp_an || segments !== exp_seg || frame_done !== exp_fd) begin
        n_err++; $display("FAIL blink k=%0d frame=%0d got an=%h seg=%h fd=%b exp an=%h seg=%h fd=%b",
                          k, f, anodes, segments, frame_done, exp_an, exp_seg, exp_fd);
      end
    end
  endtask

  task automatic test_enable_load();
    logic [7:0] exp_seg;
    logic [3:0] exp_an;
    int c, i;
    hold_reset();
    release_reset();
    load_word(16'h1234, 4'h0, 4'b1010);
    for (int e = 0; e < 15; e++) begin
      tick();
      c = (k - 1) % 4;
      i = ((k - 1) / 4) % 4;
      exp_an = 4'hF; exp_seg = 8'hFF;
      if (c != 0 && (i == 1 || i == 3)) begin
        exp_an  = ~(4'b0001 << i);
        exp_seg = (i == 3) ? 8'hC0 : ((k <= 6) ? 8'hB0 : 8'h92);
      end
      n_cmp++; if (anodes !== exp_an || segments !== exp_seg) begin
        n_err++; $display("FAIL en_load k=%0d got an=%h seg=%h exp an=%h seg=%h",
                          k, anodes, segments, exp_an, exp_seg);
      end
      if (k == 5) begin
        data = 16'h0050;
        load = 1'b1;
      end
      if (k == 6) load = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_seg;
    logic [3:0] exp_an;
    int c;
    hold_reset();
    release_reset();
    load_word(16'h1234, 4'h0, 4'hF);
    while (k < 10) tick();
    n_cmp++; if (anodes !== 4'hB || segments !== 8'hA4) begin
      n_err++; $display("FAIL rst_mid_pre got an=%h seg=%h exp an=B seg=A4", anodes, segments);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (anodes !== 4'hF || segments !== 8'hFF || frame_done !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_dark got an=%h seg=%h fd=%b exp an=F seg=FF fd=0",
                        anodes, segments, frame_done);
    end
    data = 16'h0000; digit_en = 4'hF; load = 1'b1;
    release_reset();
    tick();
    load = 1'b0;
    n_cmp++; if (anodes !== 4'hF || segments !== 8'hFF) begin
      n_err++; $display("FAIL rst_mid_guard got an=%h seg=%h exp an=F seg=FF", anodes, segments);
    end
    for (int e = 0; e < 15; e++) begin
      tick();
      c = (k - 1) % 4;
      exp_an  = (c == 0) ? 4'hF : ~(4'b0001 << (((k - 1) / 4) % 4));
      exp_seg = (c == 0) ? 8'hFF : 8'hC0;
      n_cmp++; if (anodes !== exp_an || segments !== exp_seg) begin
        n_err++; $display("FAIL rst_mid_resume k=%0d got an=%h seg=%h exp an=%h seg=%h",
                          k, anodes, segments, exp_an, exp_seg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_font();
    test_lz();
    test_blink();
    test_enable_load();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
